// File: rtl/ne_change_monitor.sv
// Qualifies an 8-bit sample stream and commits a new reference word once a candidate is stable.
// Optional sticky commit interrupt (irq/irq_clr) is enabled by defining NE_CHANGE_MONITOR_IRQ_EN.
module ne_change_monitor #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 arm,
  input  logic                 clr_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [WIDTH-1:0]     ref_out,
  output logic                 change_pulse,
  output logic [WIDTH-1:0]     change_data,
  output logic [CNT_WIDTH-1:0] change_count,
  output logic                 tracking,
`ifdef NE_CHANGE_MONITOR_IRQ_EN
  input  logic                 irq_clr,
  output logic                 irq,
`endif
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    TRACK  = 3'd2,
    QUAL   = 3'd3,
    COMMIT = 3'd4
  } state_e;

  localparam logic [3:0]           STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [WIDTH-1:0]     cand_q, cand_d;
  logic [3:0]           qual_q, qual_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 pulse_q, pulse_d;
  logic [WIDTH-1:0]     cdata_q, cdata_d;
  logic                 commit;
  logic                 xfer;
  logic [3:0]           qual_inc;

  // Handshake: a sample transfers when in_valid && in_ready at a rising CLK edge;
  // in_ready depends only on the state register and drops solely for the COMMIT cycle.
  assign in_ready = (state_q != COMMIT);
  assign tracking = (state_q == TRACK) || (state_q == QUAL);
  assign xfer     = in_valid && in_ready;
  assign qual_inc = qual_q + 4'd1;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cand_d  = cand_q;
    qual_d  = qual_q;
    count_d = count_q;
    pulse_d = 1'b0;
    cdata_d = '0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) state_d = LOAD;
      end
      LOAD: begin
        if (!arm) begin
          state_d = IDLE;
          qual_d  = 4'd0;
        end else if (xfer) begin
          ref_d   = in_data;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (!arm) begin
          state_d = IDLE;
          qual_d  = 4'd0;
        end else if (xfer && (in_data != ref_q)) begin
          cand_d = in_data;
          qual_d = 4'd1;
          if (STABLE_N == 4'd1) commit = 1'b1;
          else state_d = QUAL;
        end
      end
      QUAL: begin
        if (!arm) begin
          state_d = IDLE;
          qual_d  = 4'd0;
        end else if (xfer) begin
          if (in_data == cand_q) begin
            qual_d = qual_inc;
            if (qual_inc == STABLE_N) commit = 1'b1;
          end else if (in_data == ref_q) begin
            // Sample fell back to the reference: treat the excursion as a glitch.
            state_d = TRACK;
            qual_d  = 4'd0;
          end else begin
            cand_d = in_data;
            qual_d = 4'd1;
            if (STABLE_N == 4'd1) commit = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = arm ? TRACK : IDLE;
        qual_d  = 4'd0;
      end
      default: state_d = IDLE;
    endcase
    // cand_d covers the single-sample case where the candidate is captured on the commit edge.
    if (commit) begin
      state_d = COMMIT;
      ref_d   = cand_d;
      pulse_d = 1'b1;
      cdata_d = cand_d;
      if (count_q != CNT_MAX) count_d = count_q + CNT_WIDTH'(1);
    end
    if (clr_count) count_d = '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ref_q   <= '0;
      cand_q  <= '0;
      qual_q  <= 4'd0;
      count_q <= '0;
      pulse_q <= 1'b0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cand_q  <= cand_d;
      qual_q  <= qual_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
      cdata_q <= cdata_d;
    end
  end

`ifdef NE_CHANGE_MONITOR_IRQ_EN
  logic irq_q;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) irq_q <= 1'b0;
    else if (commit) irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end
  assign irq = irq_q;
`endif

  assign ref_out      = ref_q;
  assign change_pulse = pulse_q;
  assign change_data  = cdata_q;
  assign change_count = count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ne_change_monitor.sv
// Directed bench for ne_change_monitor: reference load, commit, glitch rejection,
// candidate replacement, counter saturation/clear, async reset and re-arm.
module tb_ne_change_monitor;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_TRACK = 3'd2,
                         S_QUAL = 3'd3, S_COMMIT = 3'd4;

  logic       CLK, RESET, arm, clr_count, in_valid, in_ready;
  logic [7:0] in_data, ref_out, change_data, change_count;
  logic       change_pulse, tracking;
  logic [2:0] state_dbg;
`ifdef NE_CHANGE_MONITOR_IRQ_EN
  logic       irq_clr, irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  ne_change_monitor #(.WIDTH(8), .STABLE_CYCLES(2), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .arm(arm), .clr_count(clr_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ref_out(ref_out), .change_pulse(change_pulse), .change_data(change_data),
    .change_count(change_count), .tracking(tracking),
`ifdef NE_CHANGE_MONITOR_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: present one sample, hold it until accepted, release after the transfer edge.
  task automatic send(input logic [7:0] d, input logic clr);
    int n = 0;
    @(negedge CLK);
    in_valid  = 1'b1;
    in_data   = d;
    while (!in_ready && n < 16) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) check_eq("send_ready_timeout", in_ready, 1);
    clr_count = clr;
    @(posedge CLK);
    #1;
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  // Scoreboard: every change pulse must match the next expected committed value.
  always @(negedge CLK) begin
    if (!RESET && change_pulse) begin
      if (exp_q.size() > 0) check_eq("pulse_data", change_data, exp_q.pop_front());
      else check_eq("spurious_pulse", change_pulse, 0);
    end
  end

  initial begin
    logic [7:0] cur, v;
    RESET = 1'b1; arm = 1'b0; clr_count = 1'b0; in_valid = 1'b0; in_data = 8'h00;
`ifdef NE_CHANGE_MONITOR_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_ref", ref_out, 0);
    check_eq("rst_pulse", change_pulse, 0);
    check_eq("rst_cdata", change_data, 0);
    check_eq("rst_count", change_count, 0);
    check_eq("rst_tracking", tracking, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_state", state_dbg, S_IDLE);

    // Arm and load the first reference
    @(negedge CLK);
    RESET = 1'b0;
    arm   = 1'b1;
    @(posedge CLK); #1;
    check_eq("arm_load_state", state_dbg, S_LOAD);
    send(8'h3C, 1'b0);
    check_eq("load_ref", ref_out, 8'h3C);
    check_eq("load_tracking", tracking, 1);
    check_eq("load_pulse", change_pulse, 0);
    send(8'h3C, 1'b0);
    send(8'h3C, 1'b0);
    check_eq("same_state", state_dbg, S_TRACK);
    check_eq("same_count", change_count, 0);

    // Two stable samples commit
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b0);
    check_eq("qual_state", state_dbg, S_QUAL);
    check_eq("qual_ref", ref_out, 8'h3C);
    send(8'hA5, 1'b0);
    check_eq("commit_pulse", change_pulse, 1);
    check_eq("commit_cdata", change_data, 8'hA5);
    check_eq("commit_ref", ref_out, 8'hA5);
    check_eq("commit_count", change_count, 1);
    check_eq("commit_ready", in_ready, 0);
    @(posedge CLK); #1;
    check_eq("post_pulse", change_pulse, 0);
    check_eq("post_cdata", change_data, 0);
    check_eq("post_ready", in_ready, 1);
    check_eq("post_state", state_dbg, S_TRACK);

    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0);
    send(8'h3C, 1'b0);
    check_eq("back_count", change_count, 2);

    // Glitch rejected
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b0);
    check_eq("glitch_state", state_dbg, S_TRACK);
    check_eq("glitch_ref", ref_out, 8'h3C);
    send(8'h3C, 1'b0);
    check_eq("glitch_count", change_count, 2);

    // Idle cycles between samples do not disturb qualification
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check_eq("gap_state", state_dbg, S_QUAL);
    send(8'hA5, 1'b0);
    check_eq("gap_ref", ref_out, 8'hA5);
    check_eq("gap_count", change_count, 3);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0);
    send(8'h3C, 1'b0);
    check_eq("ret_count", change_count, 4);

    // Candidate replacement
    exp_q.push_back(8'h22);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check_eq("repl_state", state_dbg, S_QUAL);
    check_eq("repl_ref", ref_out, 8'h3C);
    send(8'h22, 1'b0);
    check_eq("repl_cdata", change_data, 8'h22);
    check_eq("repl_ref2", ref_out, 8'h22);
    check_eq("repl_count", change_count, 5);

    // Saturation
    cur = 8'h22;
    for (int i = 5; i < 255; i++) begin
      v = (cur == 8'h22) ? 8'h5A : 8'h22;
      exp_q.push_back(v);
      send(v, 1'b0);
      send(v, 1'b0);
      cur = v;
    end
    check_eq("fill_count", change_count, 255);
    check_eq("fill_ref", ref_out, cur);
    v = (cur == 8'h22) ? 8'h5A : 8'h22;
    exp_q.push_back(v);
    send(v, 1'b0);
    send(v, 1'b0);
    cur = v;
    check_eq("sat_count", change_count, 255);

    // Clear coincident with a commit increment
    v = (cur == 8'h22) ? 8'h5A : 8'h22;
    exp_q.push_back(v);
    send(v, 1'b0);
    send(v, 1'b1);
    cur = v;
    check_eq("clr_pulse", change_pulse, 1);
    check_eq("clr_count", change_count, 0);
    v = (cur == 8'h22) ? 8'h5A : 8'h22;
    exp_q.push_back(v);
    send(v, 1'b0);
    send(v, 1'b0);
    cur = v;
    check_eq("after_clr_count", change_count, 1);

    // Asynchronous reset mid-QUAL
    send(8'h99, 1'b0);
    check_eq("pre_rst_state", state_dbg, S_QUAL);
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check_eq("arst_ref", ref_out, 0);
    check_eq("arst_count", change_count, 0);
    check_eq("arst_tracking", tracking, 0);
    check_eq("arst_ready", in_ready, 1);
    check_eq("arst_state", state_dbg, S_IDLE);
`ifdef NE_CHANGE_MONITOR_IRQ_EN
    check_eq("arst_irq", irq, 0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check_eq("rearm_state", state_dbg, S_LOAD);
    send(8'h77, 1'b0);
    check_eq("rearm_ref", ref_out, 8'h77);
    check_eq("rearm_pulse", change_pulse, 0);
    check_eq("rearm_count", change_count, 0);

    exp_q.push_back(8'h88);
    send(8'h88, 1'b0);
    send(8'h88, 1'b0);
    check_eq("c88_count", change_count, 1);
`ifdef NE_CHANGE_MONITOR_IRQ_EN
    check_eq("irq_set", irq, 1);
    repeat (3) @(posedge CLK);
    #1;
    check_eq("irq_hold", irq, 1);
    @(negedge CLK);
    irq_clr = 1'b1;
    @(posedge CLK); #1;
    irq_clr = 1'b0;
    check_eq("irq_cleared", irq, 0);
`endif

    // Disarm mid-QUAL: sample on that edge discarded, ref/count retained
    send(8'hA5, 1'b0);
    @(negedge CLK);
    arm      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check_eq("disarm_state", state_dbg, S_IDLE);
    check_eq("disarm_ref", ref_out, 8'h88);
    check_eq("disarm_count", change_count, 1);
    check_eq("disarm_pulse", change_pulse, 0);
    @(negedge CLK);
    arm = 1'b1;
    @(posedge CLK); #1;
    send(8'h3C, 1'b0);
    check_eq("reload_ref", ref_out, 8'h3C);
    check_eq("reload_count", change_count, 1);

    repeat (2) @(posedge CLK);
    #1;
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
